mem_byte_stage: RTL and testbench

Memory-access stage of the RV32I pipeline, directly downstream of the execute stage and upstream of the MEM/WB register. It executes loads and stores byte-serially over an 8-bit memory port, assembling little-endian load data with sign or zero extension. It holds the pipeline via `stallreq` for the duration of each access. Non-memory instructions pass through combinationally with no stall.

---
 rtl/mem_byte_stage.sv | 186 ++++++++++++++++++
 tb/tb_mem_byte_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_stage.sv
// mem_byte_stage: RV32I memory-access stage that performs loads and stores
// one byte at a time over an 8-bit memory port, holding the pipeline with
// stallreq while an access is in flight and assembling little-endian load
// data with sign or zero extension.
module mem_byte_stage #(
    parameter logic [6:0] OP_LOAD  = 7'b0000011,
    parameter logic [6:0] OP_STORE = 7'b0100011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i,
    input  logic        mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  cnt;
    logic [1:0]  cnt_next;
    logic [31:0] data_buf;
    logic [31:0] buf_next;

    logic        is_load;
    logic        is_store;
    logic        mem_op;
    logic [1:0]  last_idx;
    logic [31:0] load_result;

    // Decode the instruction: is it a legal load/store, and which byte index is its last one
    always_comb begin
        is_load  = (opcode_i == OP_LOAD);
        is_store = (opcode_i == OP_STORE);
        mem_op   = 1'b0;
        last_idx = 2'd0;
        case (func3_i)
            3'b000: begin
                last_idx = 2'd0;
                mem_op   = is_load | is_store;
            end
            3'b001: begin
                last_idx = 2'd1;
                mem_op   = is_load | is_store;
            end
            3'b010: begin
                last_idx = 2'd3;
                mem_op   = is_load | is_store;
            end
            3'b100: begin
                last_idx = 2'd0;
                mem_op   = is_load;
            end
            3'b101: begin
                last_idx = 2'd1;
                mem_op   = is_load;
            end
            default: begin
                last_idx = 2'd0;
                mem_op   = 1'b0;
            end
        endcase
    end

    // State, byte counter and assembly buffer registers; reset discards any partial access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            data_buf <= 32'd0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            data_buf <= buf_next;
        end
    end

    // Next-state logic: start on a legal access, advance one byte per ack, then one DONE cycle
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        buf_next   = data_buf;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    state_next = ACCESS;
                    cnt_next   = 2'd0;
                    buf_next   = 32'd0;
                end
            end
            ACCESS: begin
                if (mem_ack_i) begin
                    if (is_load) begin
                        buf_next[{cnt, 3'b000} +: 8] = mem_rdata_i;
                    end
                    if (cnt == last_idx) begin
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt + 2'd1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Extend the assembled bytes to a 32-bit write-back value according to the load width
    always_comb begin
        case (func3_i)
            3'b000:  load_result = {{24{data_buf[7]}}, data_buf[7:0]};
            3'b100:  load_result = {24'd0, data_buf[7:0]};
            3'b001:  load_result = {{16{data_buf[15]}}, data_buf[15:0]};
            3'b101:  load_result = {16'd0, data_buf[15:0]};
            default: load_result = data_buf;
        endcase
    end

    // Output logic; everything is forced to zero while reset is held so a request drops at once
    always_comb begin
        wd_o        = 5'd0;
        wreg_o      = 1'b0;
        wdata_o     = 32'd0;
        stallreq    = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'd0;
        mem_wdata_o = 8'd0;
        if (rst) begin
            case (state)
                IDLE: begin
                    wd_o = wd_i;
                    if (mem_op) begin
                        stallreq = 1'b1;
                    end else begin
                        wreg_o  = wreg_i & ~(is_load | is_store);
                        wdata_o = wdata_i;
                    end
                end
                ACCESS: begin
                    wd_o       = wd_i;
                    stallreq   = 1'b1;
                    mem_req_o  = 1'b1;
                    mem_we_o   = is_store;
                    mem_addr_o = mem_addr_i + {30'd0, cnt};
                    if (is_store) begin
                        mem_wdata_o = reg2_i[{cnt, 3'b000} +: 8];
                    end
                end
                DONE: begin
                    wd_o   = wd_i;
                    wreg_o = wreg_i;
                    if (is_load) begin
                        wdata_o = load_result;
                    end
                end
                default: begin
                    wd_o = 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_byte_stage.sv
// tb_mem_byte_stage: directed and randomized checks of mem_byte_stage against
// a byte-addressed memory model and the load/store width rules.
module tb_mem_byte_stage;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [6:0]  opcode_i;
    logic [2:0]  func3_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i;
    logic        mem_ack_i;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem_model [logic [31:0]];

    mem_byte_stage #(
        .OP_LOAD (OP_LOAD),
        .OP_STORE(OP_STORE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .opcode_i   (opcode_i),
        .func3_i    (func3_i),
        .mem_addr_i (mem_addr_i),
        .reg2_i     (reg2_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .stallreq   (stallreq),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ack_i  (mem_ack_i)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [31:0] addr);
        if (!mem_model.exists(addr)) mem_model[addr] = 8'($urandom);
        return mem_model[addr];
    endfunction

    // Number of bytes an instruction moves; 0 means it is not a memory access
    function automatic int byte_count(input logic [6:0] op, input logic [2:0] f3);
        if (op == OP_LOAD) begin
            case (f3)
                3'b000, 3'b100: return 1;
                3'b001, 3'b101: return 2;
                3'b010:         return 4;
                default:        return 0;
            endcase
        end else if (op == OP_STORE) begin
            case (f3)
                3'b000:  return 1;
                3'b001:  return 2;
                3'b010:  return 4;
                default: return 0;
            endcase
        end
        return 0;
    endfunction

    function automatic logic [31:0] expected_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] v;
        int n;
        v = 32'd0;
        n = byte_count(OP_LOAD, f3);
        for (int i = 0; i < n; i++) v = v | (32'(model_byte(addr + 32'(i))) << (8 * i));
        case (f3)
            3'b000:  return v[7]  ? (v | 32'hFFFF_FF00) : v;
            3'b001:  return v[15] ? (v | 32'hFFFF_0000) : v;
            default: return v;
        endcase
    endfunction

    // Drive one instruction and act as the memory until the stage releases it
    task automatic apply_stimulus(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] r2,
                                  input logic [4:0] wd, input logic [31:0] wdata,
                                  input int wait_min, input int wait_max,
                                  output logic [31:0] result, output int stalls);
        int n, idx, wait_left, total_waits;
        bit finished;
        logic [31:0] exp_data;
        logic        exp_wreg;
        opcode_i   = op;
        func3_i    = f3;
        mem_addr_i = addr;
        reg2_i     = r2;
        wd_i       = wd;
        wdata_i    = wdata;
        wreg_i     = 1'b1;
        mem_ack_i  = 1'b0;
        n = byte_count(op, f3);
        if (n == 0) begin
            exp_data = wdata;
            exp_wreg = (op != OP_LOAD) && (op != OP_STORE);
        end else begin
            exp_data = (op == OP_LOAD) ? expected_load(f3, addr) : 32'd0;
            exp_wreg = 1'b1;
        end
        idx = 0;
        total_waits = 0;
        stalls = 0;
        finished = 0;
        result = 32'd0;
        wait_left = int'($urandom_range(wait_max, wait_min));
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            mem_ack_i   = 1'b0;
            mem_rdata_i = 8'($urandom);
            #1;
            if (stallreq) begin
                stalls++;
                check_output("stall_wreg", 32'(wreg_o), 32'd0);
            end
            if (mem_req_o) begin
                check_output("byte_addr", mem_addr_o, addr + 32'(idx));
                check_output("byte_we", 32'(mem_we_o), 32'(op == OP_STORE));
                check_output("byte_wdata", 32'(mem_wdata_o),
                             (op == OP_STORE) ? 32'(8'(r2 >> (8 * idx))) : 32'd0);
                if (wait_left > 0) begin
                    wait_left--;
                    total_waits++;
                end else begin
                    mem_ack_i = 1'b1;
                    if (op == OP_LOAD) mem_rdata_i = model_byte(addr + 32'(idx));
                    else mem_model[addr + 32'(idx)] = 8'(r2 >> (8 * idx));
                    idx++;
                    wait_left = int'($urandom_range(wait_max, wait_min));
                end
            end else if (!stallreq) begin
                check_output("result_wdata", wdata_o, exp_data);
                check_output("result_wreg", 32'(wreg_o), 32'(exp_wreg));
                check_output("result_wd", 32'(wd_o), 32'(wd));
                result = wdata_o;
                finished = 1;
            end
            @(negedge clk);
        end
        mem_ack_i = 1'b0;
        check_output("completed", 32'(finished), 32'd1);
        check_output("bytes_moved", 32'(idx), 32'(n));
        check_output("stall_cycles", 32'(stalls), (n == 0) ? 32'd0 : 32'(1 + n + total_waits));
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_stallreq"}, 32'(stallreq), 32'd0);
        check_output({tag, "_req"}, 32'(mem_req_o), 32'd0);
        check_output({tag, "_we"}, 32'(mem_we_o), 32'd0);
        check_output({tag, "_addr"}, mem_addr_o, 32'd0);
        check_output({tag, "_mwdata"}, 32'(mem_wdata_o), 32'd0);
        check_output({tag, "_wd"}, 32'(wd_o), 32'd0);
        check_output({tag, "_wreg"}, 32'(wreg_o), 32'd0);
        check_output({tag, "_wdata"}, wdata_o, 32'd0);
    endtask

    // Directed scenarios followed by a randomized run
    initial begin
        logic [31:0] res;
        int          stalls;
        int          kind;
        logic [2:0]  f3;
        logic [6:0]  op;
        logic [31:0] addr;

        rst         = 1'b0;
        opcode_i    = OP_LOAD;
        func3_i     = 3'b010;
        mem_addr_i  = 32'h100;
        reg2_i      = 32'hDEAD_BEEF;
        wd_i        = 5'd7;
        wreg_i      = 1'b1;
        wdata_i     = 32'h5555_AAAA;
        mem_rdata_i = 8'd0;
        mem_ack_i   = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        apply_stimulus(OP_ALU, 3'b000, 32'h0, 32'h0, 5'd5, 32'h1234, 0, 0, res, stalls);
        check_output("alu_const", res, 32'h1234);

        mem_model[32'h100] = 8'h78;
        mem_model[32'h101] = 8'h56;
        mem_model[32'h102] = 8'h34;
        mem_model[32'h103] = 8'h12;
        apply_stimulus(OP_LOAD, 3'b010, 32'h100, 32'h0, 5'd3, 32'h0, 0, 0, res, stalls);
        check_output("lw_const", res, 32'h1234_5678);
        check_output("lw_stalls", 32'(stalls), 32'd5);

        mem_model[32'h300] = 8'h80;
        apply_stimulus(OP_LOAD, 3'b000, 32'h300, 32'h0, 5'd4, 32'h0, 0, 0, res, stalls);
        check_output("lb_const", res, 32'hFFFF_FF80);
        check_output("lb_stalls", 32'(stalls), 32'd2);
        apply_stimulus(OP_LOAD, 3'b100, 32'h300, 32'h0, 5'd4, 32'h0, 0, 0, res, stalls);
        check_output("lbu_const", res, 32'h0000_0080);

        mem_model[32'h310] = 8'h00;
        mem_model[32'h311] = 8'h80;
        apply_stimulus(OP_LOAD, 3'b001, 32'h310, 32'h0, 5'd9, 32'h0, 0, 0, res, stalls);
        check_output("lh_const", res, 32'hFFFF_8000);

        apply_stimulus(OP_STORE, 3'b001, 32'hFFFF_FFFF, 32'hAABB_CCDD, 5'd1, 32'h0, 0, 0, res, stalls);
        check_output("sh_stalls", 32'(stalls), 32'd3);

        apply_stimulus(OP_STORE, 3'b010, 32'h400, 32'h0102_0304, 5'd2, 32'h0, 3, 3, res, stalls);
        check_output("sw_wait_stalls", 32'(stalls), 32'd17);

        apply_stimulus(OP_LOAD, 3'b011, 32'h500, 32'h0, 5'd6, 32'hCAFE_F00D, 0, 0, res, stalls);
        apply_stimulus(OP_STORE, 3'b100, 32'h500, 32'h0, 5'd6, 32'h1357_9BDF, 0, 0, res, stalls);

        // Reset in the middle of a word load, then let it restart
        opcode_i   = OP_LOAD;
        func3_i    = 3'b010;
        mem_addr_i = 32'h200;
        wd_i       = 5'd11;
        mem_ack_i  = 1'b0;
        #1;
        check_output("mid_detect", 32'(stallreq), 32'd1);
        @(negedge clk);
        mem_ack_i = 1'b0;
        #1;
        check_output("mid_b0_addr", mem_addr_o, 32'h200);
        mem_ack_i   = 1'b1;
        mem_rdata_i = model_byte(32'h200);
        @(negedge clk);
        mem_ack_i = 1'b0;
        #1;
        check_output("mid_b1_addr", mem_addr_o, 32'h201);
        mem_ack_i   = 1'b1;
        mem_rdata_i = model_byte(32'h201);
        @(negedge clk);
        mem_ack_i = 1'b0;
        #1;
        check_output("mid_b2_req", 32'(mem_req_o), 32'd1);
        rst = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        apply_stimulus(OP_LOAD, 3'b010, 32'h200, 32'h0, 5'd11, 32'h0, 0, 1, res, stalls);

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(9, 0));
            addr = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(3, 0))) : $urandom;
            if (kind == 0) begin
                op = OP_ALU;
                f3 = 3'($urandom);
            end else if (kind == 1) begin
                op = OP_LOAD;
                case ($urandom_range(2, 0))
                    0:       f3 = 3'b011;
                    1:       f3 = 3'b110;
                    default: f3 = 3'b111;
                endcase
            end else if (kind <= 5) begin
                op = OP_LOAD;
                case ($urandom_range(4, 0))
                    0:       f3 = 3'b000;
                    1:       f3 = 3'b001;
                    2:       f3 = 3'b010;
                    3:       f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else begin
                op = OP_STORE;
                f3 = 3'($urandom_range(2, 0));
            end
            apply_stimulus(op, f3, addr, $urandom, 5'($urandom), $urandom, 0, 2, res, stalls);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
